alu_multicycle_unit: RTL and testbench
======================================

ALU_MULTICYCLE_UNIT -- requirements
Module: alu_multicycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 in_valid  input  1  operand/opcode request valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 a, b  input  WIDTH each  signed operands.
REQ-009 ALUop  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SLL, 7 SRL, 8 SRA, 9 MUL; 10-15 illegal.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 carry, zero, sign, overflow, err  output  1 each  registered flags.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL equal (state == IDLE).
REQ-015 Request SHALL be accepted on a cycle with in_valid && in_ready && !flush; a, b, ALUop latched at that edge.
REQ-016 ADD/SUB/AND/OR/XOR/NOT SHALL go IDLE -> DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-017 Shifts SHALL use shamt = b[SHW-1:0], shift one bit per cycle in BUSY; shamt 0 goes IDLE -> DONE (latency 1), else latency 1 + shamt.
REQ-018 MUL SHALL be shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY (latency WIDTH + 1); result = low WIDTH bits of signed product.
REQ-019 In DONE, result and flags SHALL hold stable while out_valid && !out_ready; DONE -> IDLE on out_ready.
REQ-020 No new request SHALL be accepted in the same cycle as the DONE -> IDLE handoff (in_ready low in DONE).
REQ-021 zero = (result == 0); sign = result[WIDTH-1] for every op.
REQ-022 ADD carry = carry-out of a + b; SUB carry = borrow (a < b unsigned); overflow = signed overflow; both 0 for logic ops.
REQ-023 Shifts: carry = last bit shifted out (0 if shamt 0); overflow 0.
REQ-024 MUL: overflow = 1 iff full signed product does not fit WIDTH bits; carry 0.
REQ-025 Illegal opcode SHALL complete with latency 1: result 0, err 1, zero 1, other flags 0; err 0 for legal ops.
REQ-026 flush SHALL force state to IDLE and out_valid to 0 next edge from any state, discarding the operation; flush overrides a simultaneous in_valid and out_ready.

Reset
REQ-027 rst_n low SHALL immediately set state IDLE, out_valid 0, result 0, all flags 0, internal counters/accumulators 0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the operation; no out_valid pulse after release.
REQ-029 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ALU_MUL_EN SHALL compile in the iterative multiplier datapath and counter.
REQ-031 Without ALU_MUL_EN, opcode 9 SHALL behave as illegal per REQ-025 and no multiplier logic SHALL be synthesised.

Structure
REQ-032 Opcode enum/constants and FSM state encoding SHALL live in shared package alu_pkg, reused by the decoder.
REQ-033 Iterative multiplier SHALL be sub-module alu_seq_mul (start/done handshake, WIDTH parameter), instantiated only under ALU_MUL_EN.
REQ-034 Shifter and single-cycle ops SHALL remain in the top module.

Verification
REQ-035 WIDTH=32, ADD a=0xFFFC1FFF, b=7, out_ready=1 -> out_valid 1 cycle later, result 0xFFFC2006, carry 0, sign 1, zero 0.
REQ-036 SUB a=5, b=7 -> result 0xFFFFFFFE, carry 1, sign 1, overflow 0; ADD a=0x7FFFFFFF, b=1 -> overflow 1, sign 1.
REQ-037 SRA a=0xFFFC1FFF, b=7 -> out_valid exactly 8 cycles after acceptance, result 0xFFFFF83F, carry 1; SLL b=0 -> latency 1, result = a, carry 0.
REQ-038 With ALU_MUL_EN: MUL a=-3, b=7 -> latency 33, result 0xFFFFFFEB, overflow 0; MUL 0x10000 x 0x10000 -> result 0, zero 1, overflow 1. Without macro: opcode 9 -> err 1, result 0.
REQ-039 out_ready held low 5 cycles in DONE -> result/flags stable, in_ready 0; flush at BUSY cycle 3 of SRL by 20 -> IDLE next cycle, no out_valid.
REQ-040 rst_n pulsed low mid-MUL -> outputs 0 immediately, in_ready 1 after release, next ADD completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by alu_multicycle_unit and its decoder.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_MUL = 4'd9
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  function automatic logic is_shift(input logic [3:0] op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add signed multiplier, one multiplier bit per cycle.
// prod/done are combinational on the final iteration so the caller can capture without an extra cycle.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);
  logic busy;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] mcand, acc, addend;
  logic [WIDTH-1:0] mplier;
  assign done = busy && cnt == CW'(WIDTH - 1);
  assign addend = mplier[0] ? mcand : '0;
  // the last multiplier bit is b's sign bit and carries weight -2^(WIDTH-1)
  assign prod = done ? acc - addend : acc + addend;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      mcand <= {{WIDTH{a[WIDTH-1]}}, a};
      mplier <= b;
      acc <= '0;
    end else if (busy) begin
      acc <= prod;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/alu_multicycle_unit.sv
// alu_multicycle_unit: multicycle ALU with bit-serial shifter and optional iterative multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 9 is treated as illegal.
import alu_pkg::*;
module alu_multicycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);
  state_e state;
  logic [3:0] op_q;
  logic [WIDTH-1:0] sh_q, sh_nxt, imm_r, fin_r;
  logic [SHW-1:0] cnt_q, shamt;
  logic [WIDTH:0] add_w, sub_w;
  logic accept, go_busy, in_busy, is_mul_q, sh_out, fin, fin_c, fin_v, fin_e;
  logic imm_c, imm_v, imm_e, mul_done, mul_ovf;
  logic [2*WIDTH-1:0] mul_prod;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .abort(flush),
    .start(accept && ALUop == OP_MUL),
    .a(a),
    .b(b),
    .done(mul_done),
    .prod(mul_prod)
  );
`else
  localparam bit MUL_EN = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif
  assign in_ready = state == S_IDLE;
  assign accept = in_valid && in_ready && !flush;
  assign shamt = b[SHW-1:0];
  assign go_busy = (is_shift(ALUop) && shamt != '0) || (MUL_EN && ALUop == OP_MUL);
  assign in_busy = state == S_BUSY;
  assign is_mul_q = op_q == OP_MUL;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign sh_nxt = op_q == OP_SLL ? sh_q << 1 :
                  op_q == OP_SRA ? {sh_q[WIDTH-1], sh_q[WIDTH-1:1]} : sh_q >> 1;
  assign sh_out = op_q == OP_SLL ? sh_q[WIDTH-1] : sh_q[0];
  // product fits iff the top WIDTH+1 bits are all sign copies
  assign mul_ovf = !(&mul_prod[2*WIDTH-1:WIDTH-1] || ~|mul_prod[2*WIDTH-1:WIDTH-1]);
  always_comb begin
    imm_r = '0;
    imm_c = 1'b0;
    imm_v = 1'b0;
    imm_e = 1'b0;
    case (ALUop)
      OP_ADD: begin
        {imm_c, imm_r} = add_w;
        imm_v = a[WIDTH-1] == b[WIDTH-1] && add_w[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB: begin
        {imm_c, imm_r} = sub_w;
        imm_v = a[WIDTH-1] != b[WIDTH-1] && sub_w[WIDTH-1] != a[WIDTH-1];
      end
      OP_AND: imm_r = a & b;
      OP_OR:  imm_r = a | b;
      OP_XOR: imm_r = a ^ b;
      OP_NOT: imm_r = ~a;
      OP_SLL, OP_SRL, OP_SRA: imm_r = a;
      default: imm_e = 1'b1;
    endcase
  end
  assign fin = (accept && !go_busy) || (in_busy && (is_mul_q ? mul_done : cnt_q == SHW'(1)));
  assign fin_r = !in_busy ? imm_r : is_mul_q ? mul_prod[WIDTH-1:0] : sh_nxt;
  assign fin_c = !in_busy ? imm_c : !is_mul_q && sh_out;
  assign fin_v = !in_busy ? imm_v : is_mul_q && mul_ovf;
  assign fin_e = !in_busy && imm_e;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      out_valid <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
      sign <= 1'b0;
      overflow <= 1'b0;
      err <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= ALUop;
        sh_q <= a;
        cnt_q <= shamt;
      end
      if (in_busy && !is_mul_q) begin
        sh_q <= sh_nxt;
        cnt_q <= cnt_q - 1'b1;
      end
      if (fin) begin
        state <= S_DONE;
        out_valid <= 1'b1;
        result <= fin_r;
        carry <= fin_c;
        overflow <= fin_v;
        err <= fin_e;
        zero <= fin_r == '0;
        sign <= fin_r[WIDTH-1];
      end else if (accept) begin
        state <= S_BUSY;
      end else if (state == S_DONE && out_ready) begin
        state <= S_IDLE;
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_multicycle_unit.sv
// tb_alu_multicycle_unit: directed and random checks of alu_multicycle_unit against an arithmetic model.
module tb_alu_multicycle_unit;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, carry, zero, sign, overflow, err;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0] ALUop = '0;
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] r;
    logic c, v, e;
    int lat;
  } exp_t;

  alu_multicycle_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .sign(sign), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t m;
    longint sx, sy, s, p;
    int sh;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y[4:0]);
    m = '{r: 32'd0, c: 1'b0, v: 1'b0, e: 1'b0, lat: 1};
    s = 0;
    p = 0;
    case (op)
      4'd0: begin
        s = sx + sy;
        m.r = x + y;
        m.c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
        m.v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd1: begin
        s = sx - sy;
        m.r = x - y;
        m.c = x < y;
        m.v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd2: m.r = x & y;
      4'd3: m.r = x | y;
      4'd4: m.r = x ^ y;
      4'd5: m.r = ~x;
      4'd6: begin m.r = x << sh; m.c = sh != 0 && x[32-sh]; m.lat = sh + 1; end
      4'd7: begin m.r = x >> sh; m.c = sh != 0 && x[sh-1]; m.lat = sh + 1; end
      4'd8: begin m.r = $signed(x) >>> sh; m.c = sh != 0 && x[sh-1]; m.lat = sh + 1; end
`ifdef ALU_MUL_EN
      4'd9: begin
        p = sx * sy;
        m.r = p[31:0];
        m.v = p != longint'($signed(m.r));
        m.lat = 33;
      end
`endif
      default: m.e = 1'b1;
    endcase
    return m;
  endfunction

  // caller is positioned at a negedge; returns at a negedge after the result handshake
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int hold);
    exp_t m;
    int lat;
    logic [36:0] snap;
    m = model(op, x, y);
    in_valid = 1'b1;
    ALUop = op;
    a = x;
    b = y;
    out_ready = hold == 0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    chk({tag, ".latency"}, 64'(lat), 64'(m.lat));
    chk({tag, ".result"}, 64'(result), 64'(m.r));
    chk({tag, ".flags czsve"}, 64'({carry, zero, sign, overflow, err}),
        64'({m.c, m.r == 32'd0, m.r[31], m.v, m.e}));
    snap = {result, carry, zero, sign, overflow, err};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold"}, 64'({snap == {result, carry, zero, sign, overflow, err}, out_valid, in_ready}),
          64'(3'b110));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".handoff"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    exp_t m;
    int seen;
    repeat (3) @(negedge clk);
    chk("reset", 64'({in_ready, out_valid, result, carry, zero, sign, overflow, err}), 64'({1'b1, 38'd0}));
    rst_n = 1'b1;
    do_op("add_req035", 4'd0, 32'hFFFC1FFF, 32'd7, 0);
    do_op("sub_req036", 4'd1, 32'd5, 32'd7, 0);
    do_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'd1, 0);
    do_op("sra_req037", 4'd8, 32'hFFFC1FFF, 32'd7, 0);
    do_op("sll_b0", 4'd6, 32'h8000_1234, 32'd0, 0);
    do_op("sll_31", 4'd6, 32'h0000_0003, 32'd31, 0);
    do_op("srl_1", 4'd7, 32'h0000_0001, 32'd1, 0);
    do_op("add_carry0", 4'd0, 32'hFFFFFFFF, 32'd1, 0);
    do_op("not", 4'd5, 32'h0F0F_00FF, 32'd0, 0);
    do_op("mul9", 4'd9, 32'hFFFFFFFD, 32'd7, 0);
    do_op("mul_ovf", 4'd9, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("illegal", 4'd13, 32'h1234, 32'h5678, 0);
    do_op("hold5", 4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5);
    // flush during the third busy cycle of a long shift
    in_valid = 1'b1; ALUop = 4'd7; a = 32'hDEAD_BEEF; b = 32'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush.state", 64'({out_valid, in_ready}), 64'(2'b01));
    seen = 0;
    repeat (25) begin @(negedge clk); if (out_valid) seen++; end
    chk("flush.no_valid", 64'(seen), 64'd0);
    do_op("after_flush", 4'd0, 32'd10, 32'd20, 0);
    // reset pulse in the middle of a long operation
    in_valid = 1'b1;
`ifdef ALU_MUL_EN
    ALUop = 4'd9;
`else
    ALUop = 4'd7;
`endif
    a = 32'h1234_5678; b = 32'd30;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", 64'({in_ready, out_valid, result, carry, zero, sign, overflow, err}), 64'({1'b1, 38'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid || !in_ready) seen++; end
    chk("rst_mid.quiet", 64'(seen), 64'd0);
    do_op("add_after_rst", 4'd0, 32'h0000_0FFF, 32'h0000_0001, 0);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [31:0] x, y;
      op = 4'($urandom_range(0, 15));
      x = $urandom;
      y = (i % 7 == 3) ? x : $urandom;
      do_op("rand", op, x, y, int'($urandom_range(0, 2)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
